text_console_writer: RTL and testbench

- Writer side of the 80x24 text-mode character buffer that the display path reads by character position.
- Accepts a byte stream over a valid/ready handshake and interprets control codes. Maintains the cursor.
- Writes glyph codes into the buffer's write port. Performs scroll and clear-screen by block copy/fill through the buffer's second read port.
- Sits between the CPU-facing console register and the dual-port character RAM.

---
 rtl/text_console_writer_pkg.sv | 31 +++
 rtl/text_console_writer_if.sv | 26 ++
 rtl/text_console_writer_cursor.sv | 82 ++++++++
 rtl/text_console_writer.sv | 163 ++++++++++++++++
 tb/tb_text_console_writer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/text_console_writer_pkg.sv
// Shared geometry, control codes and state encoding for the text console writer.
// The display-side character counter uses the same COLS/ROWS.
package text_console_writer_pkg;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 24;
    localparam int unsigned ADDR_W = 11;
    localparam int unsigned CELLS  = COLS * ROWS;
    localparam int unsigned COL_W  = 7;
    localparam int unsigned ROW_W  = 5;

    localparam logic [7:0] BLANK_CHAR   = 8'h20;
    localparam logic [7:0] CH_LF        = 8'h0A;
    localparam logic [7:0] CH_CR        = 8'h0D;
    localparam logic [7:0] CH_BS        = 8'h08;
    localparam logic [7:0] CH_FF        = 8'h0C;
    localparam logic [7:0] CH_TAB       = 8'h09;
    localparam logic [7:0] CH_PRINT_MIN = 8'h20;

    localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL     = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((ROWS - 1) * COLS);

    typedef enum logic [1:0] {
        IDLE,
        SCROLL_COPY,
        SCROLL_FILL,
        CLEAR_ALL
    } state_e;

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream input, character-RAM ports and cursor output of the console writer.
// master: the writer itself; slave: the console register / RAM side.
interface text_console_writer_if;
    import text_console_writer_pkg::*;

    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [ADDR_W-1:0] cursor_pos;

    modport master (
        input  in_data, in_valid, rd_data,
        output in_ready, wr_addr, wr_data, wr_en, rd_addr, cursor_pos
    );

    modport slave (
        output in_data, in_valid, rd_data,
        input  in_ready, wr_addr, wr_data, wr_en, rd_addr, cursor_pos
    );

endinterface

// File: rtl/text_console_writer_cursor.sv
// text_cursor: row/col tracking with registered linear cursor position.
// Commands are one-hot per cycle; row_ovf_c flags a row increment past the last row.
module text_cursor
    import text_console_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              newline,
    input  logic              ret,
    input  logic              back,
    input  logic              home,
    input  logic              tab,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              col_zero_c,
    output logic              row_ovf_c
);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic [COL_W-1:0]  tab_col;
    logic              row_inc;

    always_comb begin
        col_d     = col_q;
        row_d     = row_q;
        row_inc   = 1'b0;
        row_ovf_c = 1'b0;
        tab_col   = (col_q | COL_W'(7)) + COL_W'(1);

        if (home) begin
            col_d = '0;
            row_d = '0;
        end else if (advance) begin
            if (col_q == COL_W'(COLS - 1)) begin
                col_d   = '0;
                row_inc = 1'b1;
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (newline) begin
            col_d   = '0;
            row_inc = 1'b1;
        end else if (ret) begin
            col_d = '0;
        end else if (back) begin
            if (col_q != '0) col_d = col_q - COL_W'(1);
        end else if (tab) begin
            if (tab_col >= COL_W'(COLS)) begin
                col_d   = '0;
                row_inc = 1'b1;
            end else begin
                col_d = tab_col;
            end
        end

        // Bottom row is sticky; the owner scrolls the buffer instead.
        if (row_inc) begin
            if (row_q == ROW_W'(ROWS - 1)) row_ovf_c = 1'b1;
            else                           row_d     = row_q + ROW_W'(1);
        end

        pos_d = ADDR_W'(row_d) * COLS_A + ADDR_W'(col_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
            pos_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            pos_q <= pos_d;
        end
    end

    assign cursor_pos = pos_q;
    assign col_zero_c = (col_q == '0);

endmodule

// File: rtl/text_console_writer.sv
// Console writer: decodes a byte stream into character-RAM writes, scroll and clear.
// Define CONSOLE_TAB_EN to make 0x09 advance to the next 8-column stop.
module text_console_writer
    import text_console_writer_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RST,
    text_console_writer_if.master bus
);

    state_e            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_act_q, rd_act_d;
    logic              dvld_q, dvld_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    logic              cur_adv, cur_nl, cur_ret, cur_back, cur_home, cur_tab;
    logic [ADDR_W-1:0] cur_pos;
    logic              col_zero, row_ovf;
    logic              accept;

    text_cursor u_cursor (
        .clk        (CLK),
        .rst        (RST),
        .advance    (cur_adv),
        .newline    (cur_nl),
        .ret        (cur_ret),
        .back       (cur_back),
        .home       (cur_home),
        .tab        (cur_tab),
        .cursor_pos (cur_pos),
        .col_zero_c (col_zero),
        .row_ovf_c  (row_ovf)
    );

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        rd_act_d  = 1'b0;
        dvld_d    = rd_act_q;
        dst_d     = rd_addr_q - COLS_A;
        cnt_d     = cnt_q;
        cur_adv   = 1'b0;
        cur_nl    = 1'b0;
        cur_ret   = 1'b0;
        cur_back  = 1'b0;
        cur_home  = 1'b0;
        cur_tab   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.in_data >= CH_PRINT_MIN) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cur_pos;
                        wr_data_d = bus.in_data;
                        cur_adv   = 1'b1;
                    end else begin
                        case (bus.in_data)
                            CH_LF: cur_nl  = 1'b1;
                            CH_CR: cur_ret = 1'b1;
                            CH_BS: begin
                                cur_back = 1'b1;
                                if (!col_zero) begin
                                    wr_en_d   = 1'b1;
                                    wr_addr_d = cur_pos - ADDR_W'(1);
                                    wr_data_d = BLANK_CHAR;
                                end
                            end
                            CH_FF: begin
                                cur_home = 1'b1;
                                cnt_d    = '0;
                                state_d  = CLEAR_ALL;
                            end
`ifdef CONSOLE_TAB_EN
                            CH_TAB: cur_tab = 1'b1;
`endif
                            default: ;
                        endcase
                    end
                    if (row_ovf) begin
                        cnt_d   = COLS_A;
                        state_d = SCROLL_COPY;
                    end
                end
            end

            // cnt_q is the next source cell; data returns one cycle after each read.
            SCROLL_COPY: begin
                if (cnt_q <= LAST_CELL) begin
                    rd_addr_d = cnt_q;
                    rd_act_d  = 1'b1;
                    cnt_d     = cnt_q + ADDR_W'(1);
                end
                if (dvld_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = dst_q;
                    wr_data_d = bus.rd_data;
                    if (dst_q == LAST_ROW_BASE - ADDR_W'(1)) begin
                        cnt_d   = LAST_ROW_BASE;
                        state_d = SCROLL_FILL;
                    end
                end
            end

            SCROLL_FILL, CLEAR_ALL: begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = BLANK_CHAR;
                cnt_d     = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST_CELL) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            rd_addr_q  <= '0;
            rd_act_q   <= 1'b0;
            dvld_q     <= 1'b0;
            dst_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_addr_q  <= rd_addr_d;
            rd_act_q   <= rd_act_d;
            dvld_q     <= dvld_d;
            dst_q      <= dst_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.cursor_pos = cur_pos;

endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: RAM model, expected-write scoreboard, cursor model.
// Honors CONSOLE_TAB_EN the same way as the design build.
module tb_text_console_writer;
    import text_console_writer_pkg::*;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [7:0]        d;
    } wr_t;

    logic CLK;
    logic RST;
    logic preload;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   row_m = 0;
    int   col_m = 0;
    wr_t  exp_q[$];
    logic [7:0] mem     [CELLS];
    logic [7:0] ref_mem [CELLS];

    text_console_writer_if bus ();

    text_console_writer dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Character RAM: synchronous write, read data one cycle after rd_addr.
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < CELLS; i++) mem[i] <= 8'(i);
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= mem[bus.rd_addr];
    end

    always @(negedge CLK) begin
        if (RST === 1'b0 && bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'({bus.wr_addr, bus.wr_data}), 32'hFFFFFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr", 32'({bus.wr_addr, bus.wr_data}), 32'(e));
            end
        end
    end

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.a = ADDR_W'(a);
        e.d = d;
        exp_q.push_back(e);
        ref_mem[a] = d;
    endtask

    task automatic row_inc(output bit ovf);
        ovf = 1'b0;
        if (row_m == ROWS - 1) ovf = 1'b1;
        else                   row_m++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        bit ovf;
        ovf = 1'b0;
        if (b >= 8'h20) begin
            push_wr(row_m * COLS + col_m, b);
            if (col_m == COLS - 1) begin
                col_m = 0;
                row_inc(ovf);
            end else begin
                col_m++;
            end
        end else if (b == CH_LF) begin
            col_m = 0;
            row_inc(ovf);
        end else if (b == CH_CR) begin
            col_m = 0;
        end else if (b == CH_BS) begin
            if (col_m > 0) begin
                col_m--;
                push_wr(row_m * COLS + col_m, BLANK_CHAR);
            end
        end else if (b == CH_FF) begin
            row_m = 0;
            col_m = 0;
            for (int i = 0; i < CELLS; i++) push_wr(i, BLANK_CHAR);
        end
`ifdef CONSOLE_TAB_EN
        else if (b == CH_TAB) begin
            col_m = (col_m / 8 + 1) * 8;
            if (col_m >= COLS) begin
                col_m = 0;
                row_inc(ovf);
            end
        end
`endif
        if (ovf) begin
            for (int i = 0; i < CELLS - COLS; i++) push_wr(i, ref_mem[i + COLS]);
            for (int i = CELLS - COLS; i < CELLS; i++) push_wr(i, BLANK_CHAR);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge CLK);
        while (bus.in_ready !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        check("ready_before_send", 32'(bus.in_ready), 32'd1);
        model_byte(b);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        check("cursor_pos", 32'(bus.cursor_pos), 32'(row_m * COLS + col_m));
    endtask

    task automatic wait_idle(input int limit, input string tag);
        int n;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < limit + 10) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 32'(n <= limit), 32'd1);
        @(negedge CLK);
        check({tag, "_all_writes_done"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_mem(input string tag);
        int bad;
        bad = 0;
        for (int i = 0; i < CELLS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        RST          = 1'b1;
        preload      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'(i);
        @(negedge CLK);
        preload = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus.wr_data), 32'd0);
        check("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        check("rst_cursor", 32'(bus.cursor_pos), 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        send(8'h41);
        send(8'h42);
        check("idle_ready", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 3; i++) send(8'h43 + 8'(i));
        send(CH_LF);
        for (int i = 0; i < 3; i++) send(8'h61 + 8'(i));
        send(CH_CR);
        send(CH_BS);
        for (int i = 0; i < 3; i++) send(8'h7E - 8'(i));
        send(CH_BS);
        send(8'h01);
        send(CH_TAB);
        send(8'hFF);
        while (col_m != 0) send(8'h30 + 8'(col_m % 10));
        while (row_m != ROWS - 1) send(CH_LF);
        for (int i = 0; i < COLS - 1; i++) send(8'h41 + 8'(i % 26));
        check("cursor_last_cell", 32'(bus.cursor_pos), 32'(CELLS - 1));
        repeat (2) @(negedge CLK);
        check_mem("mem_before_preload");

        // Known pattern underneath, then scroll on a last-cell printable.
        preload = 1'b1;
        @(negedge CLK);
        preload = 1'b0;
        for (int i = 0; i < CELLS; i++) ref_mem[i] = 8'(i);
        send(8'h5A);
        check("scroll_busy", 32'(bus.in_ready), 32'd0);
        wait_idle(CELLS + 2, "scroll_len");
        check_mem("scroll_mem");
        check("scroll_mem1839", 32'(mem[CELLS - COLS - 1]), 32'h5A);
        check("scroll_mem0", 32'(mem[0]), 32'h50);
        check("scroll_mem1919", 32'(mem[CELLS - 1]), 32'h20);

        send(CH_FF);
        check("clear_busy", 32'(bus.in_ready), 32'd0);
        wait_idle(CELLS, "clear_len");
        check_mem("clear_mem");

        send(8'h61);
        send(8'h62);
        send(8'h63);
        send(CH_TAB);
        send(CH_CR);
        for (int i = 0; i < 75; i++) send(8'h20 + 8'(i));
        send(CH_TAB);

        // Start a scroll, then abort it with reset.
        while (row_m != ROWS - 1) send(CH_LF);
        send(CH_LF);
        repeat (100) @(negedge CLK);
        check("abort_busy", 32'(bus.in_ready), 32'd0);
        #2 RST = 1'b1;
        #1;
        check("abort_wr_en", 32'(bus.wr_en), 32'd0);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_cursor", 32'(bus.cursor_pos), 32'd0);
        exp_q.delete();
        row_m = 0;
        col_m = 0;
        @(negedge CLK);
        RST = 1'b0;
        send(8'h41);
        repeat (3) @(negedge CLK);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_mem0", 32'(mem[0]), 32'h41);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
